// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel integer clock divider.
package clk_div_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam int MIN_RATIO = 2;
endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: integer ratio, floor(N/2) high then ceil(N/2) low,
// ratio and enable resampled only at period boundaries.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int RATIO_W = 8
) (
    input  logic               ref_clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic [RATIO_W-1:0] div_ratio,
    output logic               div_clk,
    output logic               active,
    output logic               ratio_err
);
    localparam logic [RATIO_W-1:0] ONE     = RATIO_W'(1);
    localparam logic [RATIO_W-1:0] MIN_VAL = RATIO_W'(MIN_RATIO);

    ch_state_e          state_q, state_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic               out_q, out_d;
    logic               err_q, err_d;
    logic               ratio_ok;
    logic               sample;

    always_comb begin
        state_d  = state_q;
        ratio_d  = ratio_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        err_d    = err_q;
        ratio_ok = (div_ratio >= MIN_VAL);
        // Idle channels and channels at their last count both look at the inputs.
        sample   = (state_q == ST_IDLE) || (cnt_q == ratio_q - ONE);

        if (sample) begin
            if (clk_en && ratio_ok) begin
                state_d = ST_RUN;
                ratio_d = div_ratio;
                cnt_d   = '0;
                out_d   = 1'b1;
                err_d   = 1'b0;
            end else begin
                state_d = ST_IDLE;
                out_d   = 1'b0;
                if (clk_en) err_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + ONE;
            out_d = ((cnt_q + ONE) < (ratio_q >> 1));
        end
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ratio_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ratio_q <= ratio_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign div_clk   = out_q;
    assign active    = (state_q == ST_RUN);
    assign ratio_err = err_q;
endmodule

// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent integer dividers off one reference clock; each channel
// takes its ratio from its own RATIO_W slice of the packed ratio bus.
module multi_channel_clock_divider #(
    parameter int NUM_CH  = 4,
    parameter int RATIO_W = 8
) (
    input  logic                      I_ref_clk,
    input  logic                      I_rst_n,
    input  logic [NUM_CH*RATIO_W-1:0] I_div_ratio,
    input  logic [NUM_CH-1:0]         I_clk_en,
    output logic [NUM_CH-1:0]         o_div_clk,
    output logic [NUM_CH-1:0]         o_active,
    output logic [NUM_CH-1:0]         o_ratio_err
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .RATIO_W (RATIO_W)
        ) u_ch (
            .ref_clk   (I_ref_clk),
            .rst_n     (I_rst_n),
            .clk_en    (I_clk_en[i]),
            .div_ratio (I_div_ratio[i*RATIO_W +: RATIO_W]),
            .div_clk   (o_div_clk[i]),
            .active    (o_active[i]),
            .ratio_err (o_ratio_err[i])
        );
    end
endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Bench for multi_channel_clock_divider: directed scenarios plus random traffic,
// each cycle compared with a period-position reference model.
module tb_multi_channel_clock_divider;
    localparam int NUM_CH  = 4;
    localparam int RATIO_W = 8;

    logic                      I_ref_clk = 1'b0;
    logic                      I_rst_n   = 1'b0;
    logic [NUM_CH*RATIO_W-1:0] I_div_ratio = '0;
    logic [NUM_CH-1:0]         I_clk_en    = '0;
    logic [NUM_CH-1:0]         o_div_clk;
    logic [NUM_CH-1:0]         o_active;
    logic [NUM_CH-1:0]         o_ratio_err;

    int n_cmp  = 0;
    int n_fail = 0;

    multi_channel_clock_divider #(.NUM_CH(NUM_CH), .RATIO_W(RATIO_W)) dut (
        .I_ref_clk   (I_ref_clk),
        .I_rst_n     (I_rst_n),
        .I_div_ratio (I_div_ratio),
        .I_clk_en    (I_clk_en),
        .o_div_clk   (o_div_clk),
        .o_active    (o_active),
        .o_ratio_err (o_ratio_err)
    );

    always #5 I_ref_clk = ~I_ref_clk;

    // Reference model: each channel is either stopped or at position p of an N-cycle period.
    int m_n [NUM_CH];
    int m_p [NUM_CH];
    bit m_run [NUM_CH];
    bit m_err [NUM_CH];

    function automatic int ratio_of(input int ch);
        return int'(I_div_ratio[ch*RATIO_W +: RATIO_W]);
    endfunction

    always @(posedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_run[i] <= 1'b0; m_err[i] <= 1'b0; m_p[i] <= 0; m_n[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_run[i] && m_p[i] < m_n[i] - 1) begin
                    m_p[i] <= m_p[i] + 1;
                end else if (I_clk_en[i] && ratio_of(i) >= 2) begin
                    m_run[i] <= 1'b1; m_n[i] <= ratio_of(i); m_p[i] <= 0; m_err[i] <= 1'b0;
                end else begin
                    m_run[i] <= 1'b0;
                    if (I_clk_en[i]) m_err[i] <= 1'b1;
                end
            end
        end
    end

    function automatic logic [3*NUM_CH-1:0] exp_vec();
        logic [NUM_CH-1:0] c, a, e;
        for (int i = 0; i < NUM_CH; i++) begin
            c[i] = m_run[i] && (m_p[i] < m_n[i] / 2);
            a[i] = m_run[i];
            e[i] = m_err[i];
        end
        return {c, a, e};
    endfunction

    task automatic set_ch(input int ch, input bit en, input int r);
        I_clk_en[ch] = en;
        I_div_ratio[ch*RATIO_W +: RATIO_W] = RATIO_W'(r);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge I_ref_clk);
        n_cmp++;
        if ({o_div_clk, o_active, o_ratio_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got %h exp 0", {o_div_clk, o_active, o_ratio_err});
        end
        I_rst_n = 1'b1;
        repeat (2) begin
            @(negedge I_ref_clk);
            n_cmp++;
            if ({o_div_clk, o_active, o_ratio_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_model got %h exp %h", {o_div_clk, o_active, o_ratio_err}, exp_vec());
            end
        end
    endtask

    task automatic test_ratio2();
        set_ch(0, 1'b1, 2);
        for (int k = 0; k < 10; k++) begin
            @(negedge I_ref_clk);
            n_cmp++;
            if ({o_div_clk, o_active, o_ratio_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL ratio2_model k=%0d got %h exp %h", k, {o_div_clk, o_active, o_ratio_err}, exp_vec());
            end
            n_cmp++;
            if (o_div_clk[0] !== (k % 2 == 0) || o_active[0] !== 1'b1 || o_div_clk[3:1] !== 3'b0 || o_active[3:1] !== 3'b0) begin
                n_fail++;
                $display("FAIL ratio2_wave k=%0d got clk=%b act=%b exp clk0=%0d act=0001", k, o_div_clk, o_active, (k % 2 == 0));
            end
        end
    endtask

    task automatic test_ratio_change();
        logic [12:0] pat = '0;
        set_ch(1, 1'b1, 5);
        for (int k = 0; k < 13; k++) begin
            @(negedge I_ref_clk);
            n_cmp++;
            if ({o_div_clk, o_active, o_ratio_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL change_model k=%0d got %h exp %h", k, {o_div_clk, o_active, o_ratio_err}, exp_vec());
            end
            pat = {pat[11:0], o_div_clk[1]};
            if (k == 1) set_ch(1, 1'b1, 4);
        end
        n_cmp++;
        if (pat !== 13'b11000_1100_1100) begin
            n_fail++;
            $display("FAIL change_wave got %b exp %b", pat, 13'b11000_1100_1100);
        end
    endtask

    task automatic test_stop_restart();
        logic [11:0] pat = '0;
        logic [31:0] pat2 = '0;
        set_ch(2, 1'b1, 8);
        for (int k = 0; k < 12; k++) begin
            @(negedge I_ref_clk);
            n_cmp++;
            if ({o_div_clk, o_active, o_ratio_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL stop_model k=%0d got %h exp %h", k, {o_div_clk, o_active, o_ratio_err}, exp_vec());
            end
            pat = {pat[10:0], o_div_clk[2]};
            if (k == 1) set_ch(2, 1'b0, 8);
        end
        n_cmp++;
        if (pat !== 12'b1111_0000_0000 || o_active[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_wave got %b act=%b exp %b act=0", pat, o_active[2], 12'b1111_0000_0000);
        end
        set_ch(2, 1'b1, 16);
        for (int k = 0; k < 32; k++) begin
            @(negedge I_ref_clk);
            n_cmp++;
            if ({o_div_clk, o_active, o_ratio_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL restart_model k=%0d got %h exp %h", k, {o_div_clk, o_active, o_ratio_err}, exp_vec());
            end
            pat2 = {pat2[30:0], o_div_clk[2]};
        end
        n_cmp++;
        if (pat2 !== 32'hFF00_FF00) begin
            n_fail++;
            $display("FAIL restart_wave got %h exp ff00ff00", pat2);
        end
    endtask

    task automatic test_invalid();
        logic [5:0] pat = '0;
        set_ch(3, 1'b1, 0);
        @(negedge I_ref_clk);
        n_cmp++;
        if (o_div_clk[3] !== 1'b0 || o_active[3] !== 1'b0 || o_ratio_err[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_r0 got clk=%b act=%b err=%b exp 0 0 1", o_div_clk[3], o_active[3], o_ratio_err[3]);
        end
        set_ch(3, 1'b1, 1);
        repeat (3) begin
            @(negedge I_ref_clk);
            n_cmp++;
            if (o_div_clk[3] !== 1'b0 || o_ratio_err[3] !== 1'b1 || {o_div_clk, o_active, o_ratio_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL invalid_r1 got %h exp %h", {o_div_clk, o_active, o_ratio_err}, exp_vec());
            end
        end
        set_ch(3, 1'b1, 3);
        for (int k = 0; k < 6; k++) begin
            @(negedge I_ref_clk);
            n_cmp++;
            if (o_ratio_err[3] !== 1'b0 || {o_div_clk, o_active, o_ratio_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL invalid_recover k=%0d got %h exp %h", k, {o_div_clk, o_active, o_ratio_err}, exp_vec());
            end
            pat = {pat[4:0], o_div_clk[3]};
        end
        n_cmp++;
        if (pat !== 6'b100100) begin
            n_fail++;
            $display("FAIL invalid_wave got %b exp 100100", pat);
        end
    endtask

    task automatic test_async_reset();
        @(negedge I_ref_clk);
        #2 I_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_div_clk, o_active, o_ratio_err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got %h exp 0", {o_div_clk, o_active, o_ratio_err});
        end
        I_clk_en = '0;
        @(negedge I_ref_clk);
        I_rst_n = 1'b1;
        repeat (3) begin
            @(negedge I_ref_clk);
            n_cmp++;
            if ({o_div_clk, o_active, o_ratio_err} !== '0) begin
                n_fail++;
                $display("FAIL post_reset_idle got %h exp 0", {o_div_clk, o_active, o_ratio_err});
            end
        end
        set_ch(0, 1'b1, 2);
        @(negedge I_ref_clk);
        n_cmp++;
        if (o_div_clk[0] !== 1'b1 || {o_div_clk, o_active, o_ratio_err} !== exp_vec()) begin
            n_fail++;
            $display("FAIL post_reset_start got %h exp %h", {o_div_clk, o_active, o_ratio_err}, exp_vec());
        end
    endtask

    task automatic test_all_channels();
        int ratios [4] = '{2, 3, 7, 255};
        int highs [NUM_CH];
        int n, exp_hi;
        I_clk_en = '0;
        repeat (20) @(negedge I_ref_clk);
        for (int i = 0; i < NUM_CH; i++) begin
            set_ch(i, 1'b1, ratios[i % 4]);
            highs[i] = 0;
        end
        for (int k = 0; k < 1000; k++) begin
            @(negedge I_ref_clk);
            n_cmp++;
            if ({o_div_clk, o_active, o_ratio_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL all_model k=%0d got %h exp %h", k, {o_div_clk, o_active, o_ratio_err}, exp_vec());
            end
            for (int i = 0; i < NUM_CH; i++) highs[i] += int'(o_div_clk[i]);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            n = ratios[i % 4];
            exp_hi = (1000 / n) * (n / 2) + (((1000 % n) < n / 2) ? (1000 % n) : n / 2);
            n_cmp++;
            if (highs[i] !== exp_hi) begin
                n_fail++;
                $display("FAIL all_duty ch=%0d got %0d high exp %0d", i, highs[i], exp_hi);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            @(negedge I_ref_clk);
            n_cmp++;
            if ({o_div_clk, o_active, o_ratio_err} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model k=%0d got %h exp %h", k, {o_div_clk, o_active, o_ratio_err}, exp_vec());
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 7) == 0)
                    set_ch(i, ($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 12)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ratio2();
        test_ratio_change();
        test_stop_restart();
        test_invalid();
        test_async_reset();
        test_all_channels();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
